mem_stage_access_unit: RTL

//  MEM-stage consumer of the EX/MEM pipeline register outputs.
//  - Loads/stores: drives a req/ack data-memory port and stalls the pipeline via pipeline_wren until the access completes.
//  - Every instruction: presents the registered write-back result (rd, data, wren) to the MEM/WB boundary.
//  - Non-memory instructions pass through with one cycle of latency and no stall.

---
 rtl/mem_stage_access_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_access_unit.sv
// rtl/mem_stage_access_unit.sv - MEM-stage load/store access unit with registered write-back (optional MEM_ACCESS_TIMEOUT_EN)
module mem_stage_access_unit #(
  parameter int ADDR_WIDTH     = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           in_alu_rd_result,
  input  logic [31:0]           in_rs2_data,
  input  logic [4:0]            in_rd_address,
  input  logic                  in_reg_write_data_src,
  input  logic                  in_reg_wren,
  input  logic                  in_ram_wren,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  pipeline_wren,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [4:0]            mem_wb_rd_address,
  output logic [31:0]           mem_wb_write_data,
  output logic                  mem_wb_reg_wren,
  output logic                  mem_error
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  state_t      state_next;
  logic        mem_op;
  logic        access_done;
  logic        fsm_wren;
  logic        timeout_hit;
  logic [31:0] load_data;

  assign mem_op = in_ram_wren | (in_reg_wren & in_reg_write_data_src);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             mem_error_q;

  // The last permitted WAIT cycle completes the access on its own when no ack arrives
  assign timeout_hit = (state == S_WAIT) && !mem_ack && (wait_cnt == CNT_LAST);
  assign mem_error   = mem_error_q;

  // WAIT-cycle counter: held at zero in IDLE so it starts cleared on WAIT entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_IDLE || access_done) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag, only cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_error_q <= 1'b0;
    end else if (timeout_hit) begin
      mem_error_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_error   = 1'b0;
`endif

  // A timed-out load returns zero instead of whatever is on the bus
  assign load_data = timeout_hit ? 32'h0 : mem_rdata;

  // Reset overrides the stall so upstream stages are never frozen while in reset
  assign pipeline_wren = reset | fsm_wren;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and stall: stall on memory-op issue and until the access completes
  always_comb begin
    state_next  = state;
    fsm_wren    = 1'b1;
    access_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          fsm_wren   = 1'b0;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        access_done = mem_ack | timeout_hit;
        fsm_wren    = access_done;
        if (access_done) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Memory request and write-back registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      mem_wb_rd_address <= '0;
      mem_wb_write_data <= '0;
      mem_wb_reg_wren   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            mem_req         <= 1'b1;
            mem_we          <= in_ram_wren;
            mem_addr        <= in_alu_rd_result[ADDR_WIDTH+1:2];
            mem_wdata       <= in_rs2_data;
            mem_wb_reg_wren <= 1'b0;
          end else begin
            mem_wb_rd_address <= in_rd_address;
            mem_wb_write_data <= in_alu_rd_result;
            mem_wb_reg_wren   <= in_reg_wren;
          end
        end
        S_WAIT: begin
          if (access_done) begin
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_wb_rd_address <= in_rd_address;
            mem_wb_reg_wren   <= in_reg_wren;
            mem_wb_write_data <= in_reg_write_data_src ? load_data : in_alu_rd_result;
          end else begin
            mem_wb_reg_wren <= 1'b0;
          end
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
